// File: rtl/ramn.sv
// ramn: single-port DEPTH x WIDTH RAM with a post-reset clear sweep and registered read.
// Latency: reads return one cycle after the request (outp + out_valid pulse); writes land on the edge.
// Backpressure: no downstream stall; busy is high during the clear sweep and requests are dropped then.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; restarts the clear sweep at word 0
//   in        write data
//   addr      word address shared by read and write
//   load      write enable: mem[addr] <= in
//   rd_en     read request: outp <= mem[addr] one cycle later
//   outp      registered read data, held between accepted reads
//   out_valid one-cycle strobe marking an outp update
//   busy      clear sweep in progress
module ramn #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  // Derived from DEPTH; leave at its default.
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    addr,
  input  logic             load,
  input  logic             rd_en,
  output logic [WIDTH-1:0] outp,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [0:0]    ST_CLEAR  = 1'b0;
  localparam logic [0:0]    ST_READY  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [0:0]       state;
  logic [AW-1:0]    clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             ready;

  assign ready = (state == ST_READY);
  assign busy  = ~ready;

  // Sweep control: one word cleared per edge, DEPTH edges in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (!ready) begin
      clr_ptr <= clr_ptr + 1'b1;  // wraps to 0 at LAST_ADDR since DEPTH is 2**AW
      if (clr_ptr == LAST_ADDR) begin
        state <= ST_READY;
      end
    end
  end

  // Storage has no reset of its own; the sweep provides deterministic contents.
  // The reset edge itself performs no write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready) begin
        mem[clr_ptr] <= '0;
      end else if (load) begin
        mem[addr] <= in;
      end
    end
  end

  // Registered read. A simultaneous write to the same (only) address forwards
  // the incoming data so the read sees the new value (write-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      outp      <= '0;
      out_valid <= 1'b0;
    end else if (ready && rd_en) begin
      outp      <= load ? in : mem[addr];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ramn.sv
module tb_ramn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit overlap  = 1'b0;

  // DUT A: default 8 x 16
  logic        rst_a = 1'b1;
  logic [15:0] in_a = '0;
  logic [2:0]  addr_a = '0;
  logic        load_a = 1'b0;
  logic        rd_en_a = 1'b0;
  logic [15:0] outp_a;
  logic        out_valid_a;
  logic        busy_a;

  // DUT B: 64 x 8
  logic        rst_b = 1'b1;
  logic [7:0]  in_b = '0;
  logic [5:0]  addr_b = '0;
  logic        load_b = 1'b0;
  logic        rd_en_b = 1'b0;
  logic [7:0]  outp_b;
  logic        out_valid_b;
  logic        busy_b;

  ramn #(.WIDTH(16), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .in(in_a), .addr(addr_a), .load(load_a),
    .rd_en(rd_en_a), .outp(outp_a), .out_valid(out_valid_a), .busy(busy_a)
  );

  ramn #(.WIDTH(8), .DEPTH(64)) dut_b (
    .clk(clk), .rst(rst_b), .in(in_b), .addr(addr_b), .load(load_b),
    .rd_en(rd_en_b), .outp(outp_b), .out_valid(out_valid_b), .busy(busy_b)
  );

  logic [15:0] q_a[$];
  logic [7:0]  q_b[$];
  logic [15:0] exp_a;
  logic [7:0]  exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every out_valid consumes the oldest expected read value.
  always @(negedge clk) begin
    if (out_valid_a === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        exp_a = q_a.pop_front();
        check("a_read", {16'h0, outp_a}, {16'h0, exp_a});
      end
    end
    if (out_valid_b === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        exp_b = q_b.pop_front();
        check("b_read", {24'h0, outp_b}, {24'h0, exp_b});
      end
    end
    if ((busy_a === 1'b1 && out_valid_a === 1'b1) || (busy_b === 1'b1 && out_valid_b === 1'b1))
      overlap = 1'b1;
  end

  // One request cycle on DUT A; called at a negedge, returns at the next one.
  task automatic op_a(input logic ld, input logic rd, input logic [2:0] a,
                      input logic [15:0] d, input logic [15:0] e);
    load_a = ld; rd_en_a = rd; addr_a = a; in_a = d;
    if (rd) q_a.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_a();
    load_a = 1'b0; rd_en_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic op_b(input logic ld, input logic rd, input logic [5:0] a,
                      input logic [7:0] d, input logic [7:0] e);
    load_b = ld; rd_en_b = rd; addr_b = a; in_b = d;
    if (rd) q_b.push_back(e);
    @(negedge clk);
  endtask

  // Releases rst_a now and counts edges until busy falls; outputs must stay quiet.
  task automatic sweep_a(input string name);
    int n;
    bit bad;
    rst_a = 1'b0;
    n = 0; bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid_a !== 1'b0 || outp_a !== 16'h0) bad = 1'b1;
    end while (busy_a === 1'b1 && n < 200);
    check({name, "_clear_edges"}, n, 8);
    check({name, "_quiet_sweep"}, {31'h0, bad}, 0);
    load_a = 1'b0; rd_en_a = 1'b0;
  endtask

  task automatic clear_a(input string name, input bit junk);
    rst_a = 1'b1; load_a = junk; rd_en_a = junk; in_a = 16'hFFFF; addr_a = 3'd0;
    @(negedge clk);
    check({name, "_rst_outp"}, {16'h0, outp_a}, 0);
    check({name, "_rst_valid"}, {31'h0, out_valid_a}, 0);
    check({name, "_rst_busy"}, {31'h0, busy_a}, 1);
    @(negedge clk);
    sweep_a(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    @(negedge clk);

    // Reset/clear, then read every word back as zero.
    clear_a("init", 1'b0);
    for (int k = 0; k < 8; k++) op_a(1'b0, 1'b1, 3'(k), 16'h0, 16'h0000);
    idle_a();

    // Requests hammered during the sweep are dropped.
    clear_a("junk", 1'b1);
    for (int k = 0; k < 8; k++) op_a(1'b0, 1'b1, 3'(k), 16'h0, 16'h0000);
    idle_a();

    // Write/read-back, back-to-back reads in reverse order.
    for (int k = 0; k < 8; k++) op_a(1'b1, 1'b0, 3'(k), 16'hA500 + 16'(k), 16'h0);
    for (int k = 7; k >= 0; k--) op_a(1'b0, 1'b1, 3'(k), 16'h0, 16'hA500 + 16'(k));
    idle_a();
    idle_a();
    check("hold_outp", {16'h0, outp_a}, 32'hA500);
    check("hold_valid_low", {31'h0, out_valid_a}, 0);
    // A write without a read leaves outp alone.
    op_a(1'b1, 1'b0, 3'd0, 16'h7777, 16'h0);
    check("load_only_outp", {16'h0, outp_a}, 32'hA500);
    op_a(1'b0, 1'b1, 3'd0, 16'h0, 16'h7777);
    idle_a();

    // Write-first collision.
    op_a(1'b1, 1'b0, 3'd3, 16'h1111, 16'h0);
    op_a(1'b1, 1'b1, 3'd3, 16'h2222, 16'h2222);
    idle_a();
    op_a(1'b0, 1'b1, 3'd3, 16'h0, 16'h2222);
    idle_a();

    // Reset in the middle of a sweep.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    check("midsweep_busy", {31'h0, busy_a}, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("midsweep_rst_outp", {16'h0, outp_a}, 0);
    sweep_a("midsweep");

    // Reset in the middle of operation wipes written data.
    op_a(1'b1, 1'b0, 3'd5, 16'hBEEF, 16'h0);
    op_a(1'b0, 1'b1, 3'd5, 16'h0, 16'hBEEF);
    idle_a();
    rst_a = 1'b1;
    @(negedge clk);
    check("midop_rst_outp", {16'h0, outp_a}, 0);
    check("midop_rst_busy", {31'h0, busy_a}, 1);
    sweep_a("midop");
    op_a(1'b0, 1'b1, 3'd5, 16'h0, 16'h0000);
    idle_a();

    // 64 x 8 variant.
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_b === 1'b1 && n < 500);
    check("b_clear_edges", n, 64);
    op_b(1'b1, 1'b0, 6'd63, 8'h5A, 8'h0);
    op_b(1'b1, 1'b0, 6'd0, 8'hA5, 8'h0);
    op_b(1'b0, 1'b1, 6'd63, 8'h0, 8'h5A);
    op_b(1'b0, 1'b1, 6'd0, 8'h0, 8'hA5);
    op_b(1'b0, 1'b1, 6'd31, 8'h0, 8'h00);
    op_b(1'b0, 1'b1, 6'd1, 8'h0, 8'h00);
    load_b = 1'b0; rd_en_b = 1'b0;
    repeat (3) @(negedge clk);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("busy_valid_overlap", {31'h0, overlap}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
